// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the 32 x 32-bit register file and its fill path.
// The Regfiles block and regfile_loader both size themselves from these values.
//   REG_NUM : number of registers (load addresses wrap modulo this)
//   ADDR_W  : register address width
//   DATA_W  : register width (four input bytes)
//   BYTE_W  : width of one streamed input byte
//   ld_state_t : loader FSM encoding (IDLE=0, COLLECT=1, WRITE=2, DONE=3)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs four streamed bytes into one word, first byte in the most significant
// position. A 2-bit counter tracks how many bytes of the current word are held.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : discard any partial word (counter and word back to zero)
//   shift      : accept in_byte this cycle
//   in_byte    : byte to append
//   full       : the byte being accepted this cycle completes the word
//   word       : packed word (valid for the cycle after full)
// -----------------------------------------------------------------------------
module byte_packer
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int BYTE_W = regfile_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              full,
    output logic [DATA_W-1:0] word
);

    logic [1:0] byte_cnt;

    // The counter wraps from 3 back to 0 on the completing byte, so the next
    // word starts cleanly without an explicit clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= 2'd0;
            word     <= '0;
        end else if (clr) begin
            byte_cnt <= 2'd0;
            word     <= '0;
        end else if (shift) begin
            byte_cnt <= byte_cnt + 2'd1;
            word     <= {word[DATA_W-BYTE_W-1:0], in_byte};
        end
    end

    assign full = shift && (byte_cnt == 2'd3);

endmodule

// File: rtl/regfile_loader.sv
// -----------------------------------------------------------------------------
// regfile_loader
// Fill stage for the register file: takes a valid/ready byte stream, packs
// every four bytes MSB-first into a word and writes the words to consecutive
// register addresses starting at base_addr (wrapping modulo REG_NUM).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a load (honoured only when idle)
//   abort               : cancel the load in progress on the next edge
//   base_addr, count    : first address and number of words, latched on start
//   in_valid, in_data   : byte stream input
//   in_ready            : byte accepted this cycle when in_valid is high
//   we, waddr, wdata    : register file write port
//   busy                : load in progress
//   done                : one-cycle pulse at normal completion
// Every output is a register or a decode of the state register.
// -----------------------------------------------------------------------------
module regfile_loader
    import regfile_pkg::*;
#(
    parameter int REG_NUM = regfile_pkg::REG_NUM,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int BYTE_W  = regfile_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    ld_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remain;
    logic              load;
    logic              clr;
    logic              shift;
    logic              full;
    logic [DATA_W-1:0] word;

    byte_packer #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .shift   (shift),
        .in_byte (in_data),
        .full    (full),
        .word    (word)
    );

    // An abort in COLLECT must not let a byte slip into the packer.
    assign shift = (state == COLLECT) && in_valid && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load      = 1'b1;
                    clr       = 1'b1;
                    state_nxt = (count == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (abort) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end else if (full) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // The write itself is decoded from state, so it completes
                // even when abort arrives in this cycle.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (remain == (ADDR_W+1)'(1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = COLLECT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address pointer and remaining-word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            remain <= '0;
        end else if (load) begin
            ptr    <= base_addr;
            remain <= count;
        end else if (state == WRITE) begin
            ptr    <= (ptr == ADDR_W'(REG_NUM - 1)) ? '0 : ptr + ADDR_W'(1);
            remain <= remain - (ADDR_W+1)'(1);
        end
    end

    assign in_ready = (state == COLLECT);
    assign we       = (state == WRITE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign waddr    = ptr;
    assign wdata    = word;

endmodule

// File: tb/tb_regfile_loader.sv
// -----------------------------------------------------------------------------
// tb_regfile_loader
// Randomized self-checking bench for regfile_loader. Expected writes are built
// from the byte stream, base address and word count; observed writes are
// collected from the write port and compared in order.
// -----------------------------------------------------------------------------
module tb_regfile_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [5:0]  count = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;

    regfile_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4:0]  got_addr[$];
    logic [31:0] got_data[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (we) begin
                got_addr.push_back(waddr);
                got_data.push_back(wdata);
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] byte_q[$];

    task automatic fill_random(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    // Compare the writes captured since index wr0 with the reference list:
    // word k goes to (base + k) mod 32 and holds bytes 4k..4k+3, first byte on top.
    task automatic check_writes(input string tag, input int wr0, input int base, input int nw);
        int n_got;
        logic [31:0] exp_d;
        n_got = got_addr.size() - wr0;
        chk({tag, "_wr_count"}, n_got, nw);
        for (int k = 0; k < nw && k < n_got; k++) begin
            exp_d = (32'(byte_q[4*k]) << 24) | (32'(byte_q[4*k+1]) << 16) |
                    (32'(byte_q[4*k+2]) << 8) | 32'(byte_q[4*k+3]);
            chk({tag, "_waddr"}, got_addr[wr0+k], (base + k) % 32);
            chk({tag, "_wdata"}, got_data[wr0+k], exp_d);
        end
    endtask

    // mode: 0 = in_valid always high, 1 = toggling, 2 = random.
    // abort_at >= 0 aborts once that many bytes have been accepted.
    task automatic run_load(input string tag, input int base, input int cnt,
                            input int mode, input int abort_at);
        int b, guard, start_cyc, wr0, dn0, nbytes;
        logic hs;
        wr0    = got_addr.size();
        dn0    = done_cnt;
        nbytes = (abort_at >= 0) ? abort_at : 4 * cnt;
        start     = 1'b1;
        base_addr = 5'(base);
        count     = 6'(cnt);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_ready_after_start"}, in_ready, (cnt != 0));
        b = 0;
        guard = 0;
        while (b < nbytes && guard < 2000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = byte_q[b];
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) b++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 2000) chk({tag, "_byte_timeout"}, b, nbytes);
        if (abort_at >= 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk({tag, "_busy_after_abort"}, busy, 0);
            repeat (10) @(posedge clk);
            #1;
            chk({tag, "_no_done"}, done_cnt - dn0, 0);
            check_writes(tag, wr0, base, abort_at / 4);
        end else begin
            guard = 0;
            while (!done && guard < 400) begin
                @(posedge clk); #1;
                guard++;
            end
            chk({tag, "_done_seen"}, done, 1);
            if (mode == 0)
                chk({tag, "_done_cycles"}, cyc - start_cyc + 1, 5 * cnt + 2);
            chk({tag, "_busy_in_done"}, busy, 1);
            @(posedge clk); #1;
            chk({tag, "_busy_after_done"}, busy, 0);
            chk({tag, "_done_one_cycle"}, done, 0);
            check_writes(tag, wr0, base, cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, wr0, g;
        logic hs;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {in_ready, we, waddr, wdata, busy, done}, 41'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {in_ready, we, busy, done}, 4'd0);

        // Full 32-word load, bytes 0..127
        byte_q.delete();
        for (int i = 0; i < 128; i++) byte_q.push_back(8'(i));
        run_load("full", 0, 32, 0, -1);
        chk("reg0_data", got_data[0], 32'h00010203);

        // Address wrap
        fill_random(16);
        run_load("wrap", 30, 4, 0, -1);

        // Zero-length load
        run_load("count0", $urandom_range(0, 31), 0, 0, -1);

        // Toggling in_valid
        byte_q.delete();
        byte_q.push_back(8'hDE); byte_q.push_back(8'hAD);
        byte_q.push_back(8'hBE); byte_q.push_back(8'hEF);
        run_load("deadbeef", $urandom_range(0, 31), 1, 1, -1);
        chk("deadbeef_word", got_data[got_data.size()-1], 32'hDEADBEEF);

        // Abort after 2 bytes of word 3, then restart
        fill_random(32);
        run_load("abort", $urandom_range(0, 31), 8, 0, 14);
        fill_random(8);
        run_load("after_abort", $urandom_range(0, 31), 2, 2, -1);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; count = 6'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, in_ready}, 2'd0);

        // Reset in the middle of a load
        fill_random(16);
        wr0 = got_addr.size();
        start = 1'b1; base_addr = 5'd5; count = 6'd4;
        @(posedge clk); #1;
        start = 1'b0;
        b = 0; g = 0;
        while (b < 6 && g < 100) begin
            in_valid = 1'b1;
            in_data  = byte_q[b];
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) b++;
            g++;
        end
        chk("midrst_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_outputs", {in_ready, we, waddr, wdata, busy, done}, 41'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_writes", got_addr.size() - wr0, 1);
        @(posedge clk); #1;
        chk("midrst_idle", {busy, we, in_ready}, 3'd0);
        fill_random(20);
        run_load("after_rst", $urandom_range(0, 31), 5, 0, -1);

        // Random loads with random valid gaps
        for (int t = 0; t < 4; t++) begin
            int c;
            c = $urandom_range(1, 6);
            fill_random(4 * c);
            run_load("rand", $urandom_range(0, 31), c, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
